// File: rtl/fpa_add_arbiter.sv
// Round-robin front end that shares one external pipelined FP adder between
// N_REQ requesters and returns each sum tagged with its owner's ID.
module fpa_add_arbiter #(
  parameter int N_REQ = 4,
  parameter int LAT = 1,
  localparam int ID_W = $clog2(N_REQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [N_REQ*32-1:0]   req_a,
  input  logic [N_REQ*32-1:0]   req_b,
  input  logic [N_REQ-1:0]      req_mask,
  output logic [N_REQ-1:0]      req_ready,
  output logic [31:0]           add_a,
  output logic [31:0]           add_b,
  input  logic [31:0]           add_result,
  output logic                  rsp_valid,
  output logic [ID_W-1:0]       rsp_id,
  output logic [31:0]           rsp_data,
  output logic                  idle,
  output logic [31:0]           issued_count
);

  logic [N_REQ-1:0] elig_s;
  logic [N_REQ-1:0] grant_s;
  logic [ID_W-1:0]  grant_id_s;
  logic [ID_W-1:0]  cand_s;
  logic             hit_s;
  logic             found_s;
  logic [31:0]      sel_a_s;
  logic [31:0]      sel_b_s;
  logic [LAT:0]     tag_vld_next_s;

  logic [ID_W-1:0]  rr_ptr_r;
  logic [LAT:0]     tag_vld_r;
  logic [ID_W-1:0]  tag_id_r [0:LAT];
  logic [31:0]      add_a_r;
  logic [31:0]      add_b_r;
  logic             rsp_valid_r;
  logic [ID_W-1:0]  rsp_id_r;
  logic [31:0]      rsp_data_r;
  logic             idle_r;
  logic [31:0]      issued_count_r;

  assign elig_s = req_valid & req_mask;

  // Circular search starting just after the last granted requester.
  always_comb begin
    grant_s    = '0;
    grant_id_s = '0;
    cand_s     = '0;
    hit_s      = 1'b0;
    found_s    = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand_s             = ID_W'((int'(rr_ptr_r) + k) % N_REQ);
      hit_s              = elig_s[cand_s] & ~found_s;
      grant_s[cand_s]    = grant_s[cand_s] | hit_s;
      grant_id_s         = hit_s ? cand_s : grant_id_s;
      found_s            = found_s | hit_s;
    end
  end

  // One-hot AND-OR operand mux driven by the grant vector.
  always_comb begin
    sel_a_s = 32'd0;
    sel_b_s = 32'd0;
    for (int i = 0; i < N_REQ; i++) begin
      sel_a_s = sel_a_s | ({32{grant_s[i]}} & req_a[i*32 +: 32]);
      sel_b_s = sel_b_s | ({32{grant_s[i]}} & req_b[i*32 +: 32]);
    end
  end

  // Stage 0 tracks the op sitting on add_a/add_b; stage LAT lines up with add_result.
  assign tag_vld_next_s = {tag_vld_r[LAT-1:0], found_s};

  // Arbiter pointer, operand registers, tag pipeline and response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_r       <= ID_W'(N_REQ - 1);
      tag_vld_r      <= '0;
      for (int s = 0; s <= LAT; s++) begin
        tag_id_r[s] <= '0;
      end
      add_a_r        <= 32'd0;
      add_b_r        <= 32'd0;
      rsp_valid_r    <= 1'b0;
      rsp_id_r       <= '0;
      rsp_data_r     <= 32'd0;
      idle_r         <= 1'b1;
      issued_count_r <= 32'd0;
    end else begin
      if (found_s) begin
        add_a_r        <= sel_a_s;
        add_b_r        <= sel_b_s;
        rr_ptr_r       <= grant_id_s;
        issued_count_r <= issued_count_r + 32'd1;
      end
      tag_vld_r   <= tag_vld_next_s;
      tag_id_r[0] <= grant_id_s;
      for (int s = 1; s <= LAT; s++) begin
        tag_id_r[s] <= tag_id_r[s-1];
      end
      rsp_valid_r <= tag_vld_r[LAT];
      if (tag_vld_r[LAT]) begin
        rsp_id_r   <= tag_id_r[LAT];
        rsp_data_r <= add_result;
      end
      // Computed from next-state values so idle lines up with the other outputs.
      idle_r <= ~(|tag_vld_next_s) & ~tag_vld_r[LAT];
    end
  end

  assign req_ready    = grant_s;
  assign add_a        = add_a_r;
  assign add_b        = add_b_r;
  assign rsp_valid    = rsp_valid_r;
  assign rsp_id       = rsp_id_r;
  assign rsp_data     = rsp_data_r;
  assign idle         = idle_r;
  assign issued_count = issued_count_r;

endmodule
